contador_programa: RTL

CONTADOR_PROGRAMA -- requirements
Module: contador_programa

---
 rtl/pkg_riscv.sv | 13 +
 rtl/calc_alvo.sv | 22 ++
 rtl/contador_programa.sv | 93 +++++++++
 3 files changed

// File: rtl/pkg_riscv.sv
// rtl/pkg_riscv.sv - shared state encodings and sizing for the program counter
package pkg_riscv;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    RUN   = 2'b01,
    REDIR = 2'b10,
    HALT  = 2'b11
  } estado_t;

  localparam int MEM_WORDS_PADRAO = 12;

endpackage

// File: rtl/calc_alvo.sv
// rtl/calc_alvo.sv - redirect target selection, branch adder and range check
module calc_alvo
  import pkg_riscv::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_PADRAO
) (
  input  logic        salto_en,
  input  logic [31:0] salto_alvo,
  input  logic [31:0] desvio_pc,
  input  logic [31:0] desvio_offset,
  output logic [31:0] alvo,
  output logic        fora_faixa
);

  logic [31:0] soma;

  // Branch target wraps modulo 2^32; the range test is unsigned.
  assign soma       = desvio_pc + desvio_offset;
  assign alvo       = salto_en ? salto_alvo : soma;
  assign fora_faixa = (alvo >= 32'(MEM_WORDS));

endmodule

// File: rtl/contador_programa.sv
// rtl/contador_programa.sv - fetch program counter with jump/branch redirect and halt
module contador_programa
  import pkg_riscv::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_PADRAO,
  parameter int RESET_PC  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        salto_en,
  input  logic [31:0] salto_alvo,
  input  logic        desvio_en,
  input  logic [31:0] desvio_pc,
  input  logic [31:0] desvio_offset,
  output logic [31:0] PC,
  output logic        pc_valido,
  output logic        flush,
  output logic        fim,
  output logic        erro,
  output logic [31:0] ciclos
);

  localparam logic [31:0] ULTIMO_PC = 32'(MEM_WORDS - 1);

  estado_t     estado, estado_n;
  logic [31:0] pc_n, ciclos_n;
  logic        erro_n;
  logic [31:0] alvo;
  logic        fora_faixa;

  calc_alvo #(.MEM_WORDS(MEM_WORDS)) u_calc_alvo (
    .salto_en      (salto_en),
    .salto_alvo    (salto_alvo),
    .desvio_pc     (desvio_pc),
    .desvio_offset (desvio_offset),
    .alvo          (alvo),
    .fora_faixa    (fora_faixa)
  );

  always_comb begin
    estado_n = estado;
    pc_n     = PC;
    ciclos_n = ciclos;
    erro_n   = erro;
    case (estado)
      INIT:  estado_n = RUN;
      RUN: begin
        if (salto_en || desvio_en) begin
          if (fora_faixa) begin
            estado_n = HALT;
            erro_n   = 1'b1;
          end else begin
            pc_n     = alvo;
            estado_n = REDIR;
          end
        end else if (stall) begin
          estado_n = RUN;
        end else if (PC == ULTIMO_PC) begin
          estado_n = HALT;
        end else begin
          pc_n = PC + 32'd1;
          if (ciclos != 32'hFFFF_FFFF) ciclos_n = ciclos + 32'd1;
        end
      end
      REDIR: estado_n = RUN;
      HALT:  estado_n = HALT;
      default: estado_n = INIT;
    endcase
  end

  // Flags are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= INIT;
      PC        <= 32'(RESET_PC);
      ciclos    <= 32'd0;
      erro      <= 1'b0;
      pc_valido <= 1'b0;
      flush     <= 1'b0;
      fim       <= 1'b0;
    end else begin
      estado    <= estado_n;
      PC        <= pc_n;
      ciclos    <= ciclos_n;
      erro      <= erro_n;
      pc_valido <= (estado_n == RUN);
      flush     <= (estado_n == REDIR);
      fim       <= (estado_n == HALT);
    end
  end

endmodule
